// File: rtl/restoring_divider_8bit_pkg.sv
// Shared arithmetic-unit constants for the divider: default operand width,
// FSM state encoding and the iteration-counter width helper.
package restoring_divider_8bit_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // The step counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/restoring_divider_8bit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor, keep the result only if no borrow.
module restoring_divider_8bit_div_step
  import restoring_divider_8bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Trial subtraction one bit wider than R so the top bit is the borrow.
  always_comb begin
    shifted = {r_in, q_in[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    borrow  = trial[WIDTH+1];
    r_out   = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    q_out   = {q_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/restoring_divider_8bit.sv
// Multi-cycle unsigned restoring divider. Start is accepted in IDLE; a zero
// divisor short-circuits straight to DONE with quotient all ones.
// Handshake: start is only looked at in IDLE (one-cycle request, no ready);
// done is a one-cycle pulse, and quotient/remainder/div_by_zero are valid
// from that pulse until the next accepted start. busy covers the RUN cycles.
module restoring_divider_8bit
  import restoring_divider_8bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int              CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [WIDTH:0]   r_q, r_nxt;
  logic [WIDTH-1:0] q_q, q_nxt;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             last_step;

  assign accept    = (state == ST_IDLE) && start;
  assign last_step = (state == ST_RUN) && (cnt_q == LAST_STEP);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  restoring_divider_8bit_div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (d_q),
    .r_out   (r_nxt),
    .q_out   (q_nxt)
  );

  // State register; reset always wins and drops any division in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == LAST_STEP) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, one step per RUN cycle, and
  // publish the final step's outputs directly into the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r_q         <= '0;
      q_q         <= dividend;
      d_q         <= divisor;
      cnt_q       <= '0;
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == ST_RUN) begin
      r_q   <= r_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Bench for restoring_divider_8bit: directed cases plus a randomized
// back-to-back sweep scored against a plain-arithmetic reference model.
module tb_restoring_divider_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;
  logic [1:0]   dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [2*W:0] exp_q[$];

  restoring_divider_8bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: {quotient, remainder, div_by_zero} from plain arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {8'hFF, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  // Issue one division; lat = edges counted from (and including) the
  // accepting edge up to the edge that raised done, -1 on timeout.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, input logic [W-1:0] da, input logic [W-1:0] db,
                        output logic [2*W:0] got, output int lat, output int busy_cnt,
                        output bit bad_pulse);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_cnt = 0; bad_pulse = 1'b0;
    while (1) begin
      if (busy) busy_cnt++;
      if (busy && done) bad_pulse = 1'b1;
      if (done || lat >= 30) break;
      if (disturb && lat >= 2 && lat <= 5) begin
        start = 1'b1; dividend = da; divisor = db;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) lat = -1;
    got = {quotient, remainder, div_by_zero};
    @(posedge clk); #1;
    if (done) bad_pulse = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[3] = '{8'd100, 8'd255, 8'd200};
    logic [W-1:0] tb[3] = '{8'd7,   8'd1,   8'd255};
    logic [W-1:0] tq[3] = '{8'd14,  8'd255, 8'd0};
    logic [W-1:0] tr[3] = '{8'd2,   8'd0,   8'd200};
    logic [2*W:0] got;
    int lat, bc;
    bit bp;
    for (int i = 0; i < 3; i++) begin
      do_div(ta[i], tb[i], 1'b0, '0, '0, got, lat, bc, bp);
      vectors++;
      if (got !== {tq[i], tr[i], 1'b0}) begin
        miscompares++;
        $display("FAIL directed_%0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=0",
                 ta[i], tb[i], got[2*W:W+1], got[W:1], got[0], tq[i], tr[i]);
      end
      vectors++;
      if (lat !== W + 1) begin
        miscompares++;
        $display("FAIL directed_latency_%0d/%0d: got %0d edges expected %0d", ta[i], tb[i], lat, W + 1);
      end
      vectors++;
      if (bc !== W || bp !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_busy_%0d/%0d: got busy_cycles=%0d overlap_or_long_done=%b expected %0d,0",
                 ta[i], tb[i], bc, bp, W);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*W:0] got;
    int lat, bc;
    bit bp;
    do_div(8'd5, 8'd0, 1'b0, '0, '0, got, lat, bc, bp);
    vectors++;
    if (got !== {8'd255, 8'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL div_zero_result: got q=%0d r=%0d dz=%b expected q=255 r=5 dz=1",
               got[2*W:W+1], got[W:1], got[0]);
    end
    vectors++;
    if (lat !== 1 || bc !== 0 || bp !== 1'b0) begin
      miscompares++;
      $display("FAIL div_zero_timing: got lat=%0d busy_cycles=%0d bad_pulse=%b expected 1,0,0", lat, bc, bp);
    end
  endtask

  task automatic test_hold();
    logic [2*W:0] got;
    int lat, bc;
    bit bp, bad;
    do_div(8'd100, 8'd7, 1'b0, '0, '0, got, lat, bc, bp);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dividend = W'($urandom); divisor = W'($urandom);
      @(posedge clk); #1;
      if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0} || done || busy) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_results: got q=%0d r=%0d dz=%b done=%b expected 14 2 0 held, done=0",
               quotient, remainder, div_by_zero, done);
    end
  endtask

  task automatic test_ignore_start();
    logic [2*W:0] got;
    int lat, bc;
    bit bp;
    do_div(8'd100, 8'd7, 1'b1, 8'd9, 8'd3, got, lat, bc, bp);
    vectors++;
    if (got !== {8'd14, 8'd2, 1'b0} || lat !== W + 1) begin
      miscompares++;
      $display("FAIL ignore_start: got q=%0d r=%0d dz=%b lat=%0d expected 14 2 0 lat=%0d",
               got[2*W:W+1], got[W:1], got[0], lat, W + 1);
    end
    // The ignored request must not be picked up once the divider is idle.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    logic [2*W:0] got;
    int lat, bc;
    bit bp, seen_done;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got activity=%b expected 0", seen_done);
    end
    do_div(8'd50, 8'd5, 1'b0, '0, '0, got, lat, bc, bp);
    vectors++;
    if (got !== {8'd10, 8'd0, 1'b0} || lat !== W + 1) begin
      miscompares++;
      $display("FAIL abort_restart: got q=%0d r=%0d dz=%b lat=%0d expected 10 0 0 lat=%0d",
               got[2*W:W+1], got[W:1], got[0], lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] got, exp;
    logic [W-1:0] a, b;
    int lat, bc, sel;
    bit bp, dis;
    for (int n = 0; n < 1000; n++) begin
      a   = W'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel <= 3) b = W'($urandom_range(1, 15));
      else               b = W'($urandom_range(0, 255));
      dis = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_div(a, b));
      do_div(a, b, dis, W'($urandom), W'($urandom), got, lat, bc, bp);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                 a, b, got[2*W:W+1], got[W:1], got[0], exp[2*W:W+1], exp[W:1], exp[0]);
      end
      vectors++;
      if (lat !== ((b == 0) ? 1 : W + 1) || bc !== ((b == 0) ? 0 : W) || bp !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_timing %0d/%0d: got lat=%0d busy_cycles=%0d bad_pulse=%b",
                 a, b, lat, bc, bp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_hold();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
